// File: rtl/arbitro_mux2.sv
// Two-requester round-robin arbiter for the shared 2:1 datapath mux.
// It owns the mux select and registers the selected operand with a valid flag.
module arbitro_mux2 #(
    parameter int LARGURA   = 4,
    parameter int MAX_POSSE = 4,
    parameter int LARG_CONT = 3
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Req0,
    input  logic               Req1,
    input  logic               Liberar0,
    input  logic               Liberar1,
    input  logic [LARGURA-1:0] Entrada0,
    input  logic [LARGURA-1:0] Entrada1,
    output logic               Grant0,
    output logic               Grant1,
    output logic               Controle,
    output logic [LARGURA-1:0] Resultado,
    output logic               Valido,
    output logic               Ocupado
);

    typedef enum logic [1:0] {
        LIVRE  = 2'd0,
        POSSE0 = 2'd1,
        POSSE1 = 2'd2
    } estado_t;

    localparam logic [LARG_CONT-1:0] CONT_MAX = LARG_CONT'(MAX_POSSE - 1);

    estado_t              estado_q,    estado_d;
    logic [LARG_CONT-1:0] contador_q,  contador_d;
    logic                 ultimo_q,    ultimo_d;
    logic                 controle_q,  controle_d;
    logic [LARGURA-1:0]   resultado_q, resultado_d;
    logic                 valido_q,    valido_d;

    logic libera;
    logic estouro;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            estado_q    <= LIVRE;
            contador_q  <= '0;
            ultimo_q    <= 1'b1;
            controle_q  <= 1'b0;
            resultado_q <= '0;
            valido_q    <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            contador_q  <= contador_d;
            ultimo_q    <= ultimo_d;
            controle_q  <= controle_d;
            resultado_q <= resultado_d;
            valido_q    <= valido_d;
        end
    end

    always_comb begin
        estado_d   = estado_q;
        contador_d = contador_q;
        ultimo_d   = ultimo_q;
        libera     = 1'b0;
        estouro    = 1'b0;
        case (estado_q)
            LIVRE: begin
                contador_d = '0;
                // On a tie the requester that did not hold the mux last wins.
                if (Req0 && Req1)
                    estado_d = ultimo_q ? POSSE0 : POSSE1;
                else if (Req0)
                    estado_d = POSSE0;
                else if (Req1)
                    estado_d = POSSE1;
            end
            POSSE0: begin
                libera  = Liberar0 || !Req0;
                estouro = (contador_q == CONT_MAX) && Req1;
                if ((libera || estouro) && Req1) begin
                    estado_d   = POSSE1;
                    contador_d = '0;
                    ultimo_d   = 1'b0;
                end else if (libera) begin
                    estado_d   = LIVRE;
                    contador_d = '0;
                    ultimo_d   = 1'b0;
                end else if (contador_q != CONT_MAX) begin
                    contador_d = contador_q + 1'b1;
                end
            end
            POSSE1: begin
                libera  = Liberar1 || !Req1;
                estouro = (contador_q == CONT_MAX) && Req0;
                if ((libera || estouro) && Req0) begin
                    estado_d   = POSSE0;
                    contador_d = '0;
                    ultimo_d   = 1'b1;
                end else if (libera) begin
                    estado_d   = LIVRE;
                    contador_d = '0;
                    ultimo_d   = 1'b1;
                end else if (contador_q != CONT_MAX) begin
                    contador_d = contador_q + 1'b1;
                end
            end
            default: begin
                estado_d   = LIVRE;
                contador_d = '0;
            end
        endcase
    end

    // Select follows the next owner so it is aligned with the grant; idle keeps it.
    always_comb begin
        controle_d = controle_q;
        if (estado_d == POSSE1)
            controle_d = 1'b1;
        else if (estado_d == POSSE0)
            controle_d = 1'b0;
    end

    always_comb begin
        resultado_d = resultado_q;
        valido_d    = 1'b0;
        if (estado_q == POSSE0) begin
            resultado_d = Entrada0;
            valido_d    = 1'b1;
        end else if (estado_q == POSSE1) begin
            resultado_d = Entrada1;
            valido_d    = 1'b1;
        end
    end

    assign Grant0    = (estado_q == POSSE0);
    assign Grant1    = (estado_q == POSSE1);
    assign Ocupado   = (estado_q == POSSE0) || (estado_q == POSSE1);
    assign Controle  = controle_q;
    assign Resultado = resultado_q;
    assign Valido    = valido_q;

endmodule

// File: tb/tb_arbitro_mux2.sv
// Directed bench for arbitro_mux2: reset, grant latency, timeout rotation,
// back-to-back handoff, indefinite hold, mid-grant reset and a random fairness run.
module tb_arbitro_mux2;

    localparam int LARGURA   = 4;
    localparam int MAX_POSSE = 4;

    logic               Clock = 1'b0;
    logic               Reset;
    logic               Req0, Req1, Liberar0, Liberar1;
    logic [LARGURA-1:0] Entrada0, Entrada1;
    logic               Grant0, Grant1, Controle, Valido, Ocupado;
    logic [LARGURA-1:0] Resultado;

    int checks = 0;
    int errors = 0;

    arbitro_mux2 #(.LARGURA(LARGURA), .MAX_POSSE(MAX_POSSE), .LARG_CONT(3)) dut (
        .Clock(Clock), .Reset(Reset),
        .Req0(Req0), .Req1(Req1), .Liberar0(Liberar0), .Liberar1(Liberar1),
        .Entrada0(Entrada0), .Entrada1(Entrada1),
        .Grant0(Grant0), .Grant1(Grant1), .Controle(Controle),
        .Resultado(Resultado), .Valido(Valido), .Ocupado(Ocupado)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int w0, w1;
    logic r0, r1;

    initial begin
        Reset = 1'b1; Req0 = 0; Req1 = 0; Liberar0 = 0; Liberar1 = 0;
        Entrada0 = '0; Entrada1 = '0;
        tick(); tick();
        chk("rst_grant0", Grant0, 0);
        chk("rst_grant1", Grant1, 0);
        chk("rst_controle", Controle, 0);
        chk("rst_resultado", Resultado, 0);
        chk("rst_valido", Valido, 0);
        chk("rst_ocupado", Ocupado, 0);

        // single requester: grant after one edge, data after two
        Reset = 0; Req0 = 1; Entrada0 = 4'b1010;
        tick();
        chk("t1_grant0", Grant0, 1);
        chk("t1_controle", Controle, 0);
        chk("t1_ocupado", Ocupado, 1);
        chk("t1_valido_lag", Valido, 0);
        tick();
        chk("t1_resultado", Resultado, 4'b1010);
        chk("t1_valido", Valido, 1);
        Req0 = 0;
        tick();
        chk("t1_rel_grant0", Grant0, 0);
        tick();
        chk("t1_idle_valido", Valido, 0);
        chk("t1_idle_resultado", Resultado, 4'b1010);

        // tie after reset goes to 0; timeout rotates after 4 grant cycles
        Reset = 1; tick(); Reset = 0;
        Req0 = 1; Req1 = 1; Entrada0 = 4'h3; Entrada1 = 4'b0101;
        for (int i = 0; i < MAX_POSSE; i++) begin
            tick();
            chk("t2_hold0", {Grant1, Grant0}, 2'b01);
        end
        tick();
        chk("t2_to1_grants", {Grant1, Grant0}, 2'b10);
        chk("t2_to1_controle", Controle, 1);
        chk("t2_to1_resultado", Resultado, 4'h3);
        tick();
        chk("t2_res1", Resultado, 4'b0101);
        chk("t2_val1", Valido, 1);
        tick(); tick();
        chk("t2_hold1_last", {Grant1, Grant0}, 2'b10);
        tick();
        chk("t2_back0", {Grant1, Grant0}, 2'b01);
        chk("t2_back0_ctl", Controle, 0);

        // handoff on Liberar with no idle cycle
        Liberar0 = 1;
        tick();
        Liberar0 = 0;
        chk("t3_g1", {Grant1, Grant0}, 2'b10);
        Liberar1 = 1;
        tick();
        Liberar1 = 0;
        chk("t3_g0", {Grant1, Grant0}, 2'b01);
        chk("t3_valido", Valido, 1);
        chk("t3_resultado", Resultado, 4'b0101);

        // Req1 alone holds without timeout
        Req0 = 0;
        tick();
        chk("t4_g1", {Grant1, Grant0}, 2'b10);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_hold", {Grant1, Grant0}, 2'b10);
        end
        Req1 = 0;
        tick();
        chk("t4_livre", Ocupado, 0);
        chk("t4_ctl_hold", Controle, 1);
        chk("t4_val_last", Valido, 1);
        tick();
        chk("t4_val_idle", Valido, 0);
        chk("t4_ctl_idle", Controle, 1);

        // reset in the middle of a POSSE1 grant
        Req1 = 1; Entrada1 = 4'b0111;
        tick(); tick();
        chk("t5_pre_res", Resultado, 4'b0111);
        chk("t5_pre_g1", Grant1, 1);
        Reset = 1; Req0 = 1; Req1 = 1;
        tick();
        chk("t5_rst_grants", {Grant1, Grant0}, 2'b00);
        chk("t5_rst_ctl", Controle, 0);
        chk("t5_rst_res", Resultado, 0);
        chk("t5_rst_val", Valido, 0);
        chk("t5_rst_ocu", Ocupado, 0);
        Reset = 0;
        tick();
        chk("t5_tie_g0", {Grant1, Grant0}, 2'b01);

        // random traffic: mutual exclusion and bounded wait
        Req0 = 0; Req1 = 0;
        tick(); tick();
        w0 = 0; w1 = 0;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) Req0 = ~Req0;
            if ($urandom_range(0, 3) == 0) Req1 = ~Req1;
            Liberar0 = ($urandom_range(0, 7) == 0);
            Liberar1 = ($urandom_range(0, 7) == 0);
            Entrada0 = 4'($urandom);
            Entrada1 = 4'($urandom);
            r0 = Req0; r1 = Req1;
            tick();
            chk("rnd_mutex", {31'd0, Grant0 & Grant1}, 0);
            w0 = (r0 && !Grant0) ? w0 + 1 : 0;
            w1 = (r1 && !Grant1) ? w1 + 1 : 0;
            chk("rnd_wait0", {31'd0, w0 > MAX_POSSE + 1}, 0);
            chk("rnd_wait1", {31'd0, w1 > MAX_POSSE + 1}, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
